sisc_ifetch: RTL and testbench
==============================

# sisc_ifetch

Instruction-fetch stage for the SISC processor, directly upstream of the control FSM. Holds the program counter and instruction register, runs a request/valid read of instruction memory when the control unit enters fetch, and presents the latched opcode/mm fields the control FSM decodes. It also resolves conditional branches (BRA/BRR/BNE/BNR) against the status register when the control unit signals execute.

## Interface
- PC_W, 16, program counter / instruction address width
- IW, 32, instruction width
- RST_VEC, 0, PC value after reset
- clk  in  1  system clock, posedge active
- rst_f  in  1  reset, asynchronous, active-low
- fetch_go  in  1  one-cycle pulse from control FSM in fetch state
- br_go  in  1  one-cycle pulse from control FSM in execute state
- stat  in  4  status register output
- imem_addr  out  PC_W  instruction memory address
- imem_rd  out  1  read request
- imem_rdata  in  IW  read data
- imem_vld  in  1  read data valid
- ir  out  IW  instruction register
- opcode  out  4  ir[31:28]
- mm  out  4  ir[27:24]
- pc  out  PC_W  current PC (address of next instruction)
- ir_vld  out  1  ir holds a fetched instruction
- busy  out  1  read outstanding
- br_taken  out  1  one-cycle pulse: branch taken
- halted  out  1  HLT latched

## Operation
- States: IDLE, WAIT, HALT. busy = (state == WAIT).
- IDLE + fetch_go: imem_addr <= pc, imem_rd <= 1, go WAIT.
- WAIT + imem_vld: ir <= imem_rdata, pc <= pc + 1 (mod 2^PC_W, FFFF wraps to 0000), ir_vld <= 1, imem_rd <= 0. If imem_rdata[31:28] == 15 go HALT, else IDLE.
- WAIT: fetch_go and br_go ignored; imem_rd and imem_addr held stable.
- HALT: halted = 1; fetch_go/br_go ignored until reset.
- IDLE + br_go, evaluated on current ir:
  - BRA(4), BRR(5): taken iff (stat & mm) != 0.
  - BNE(6), BNR(7): taken iff (stat & mm) == 0.
  - BRA/BNE target = ir[PC_W-1:0]. BRR/BNR target = pc + sign-extended ir[15:0], mod 2^PC_W.
  - Taken: pc <= target, br_taken pulses 1 cycle. Other opcodes: no effect, br_taken 0.
- IDLE + fetch_go and br_go in the same cycle: branch applied first; imem_addr is the post-branch PC.
- imem_vld outside WAIT ignored.

## Timing
- Reset values: pc = RST_VEC, ir = 0 (NOOP), ir_vld 0, imem_rd 0, imem_addr 0, br_taken 0, halted 0, state IDLE.
- fetch_go sampled at edge N: imem_rd high from N to the capture edge. imem_vld at edge N+k (k ≥ 1): ir, pc, ir_vld update at that edge. Minimum fetch latency is 1 cycle.
- br_go at edge N: pc and br_taken valid after edge N. br_taken clears at N+1.
- Reset mid-WAIT: read abandoned, all outputs go to reset values asynchronously. A later imem_vld is ignored.

## Configuration
- IFETCH_WAIT_EN defined: variable-latency memory, capture gated by imem_vld as above.
- Undefined: imem_vld ignored. WAIT lasts exactly one cycle, and imem_rdata is captured at the first edge after imem_rd asserts.

## Structure
- Shared package sisc_pkg: opcode constants (NOOP, LOD, STR, SWP, BRA, BRR, BNE, BNR, ALU_OP, HLT), instruction field positions, ifetch state enum.
- Sub-module sisc_br_cond: combinational taken and target computation from ir, pc, stat.

## Test plan
- Reset, fetch_go, imem_vld after 3 cycles with data 0x88120000 -> ir = 0x88120000, opcode 8, mm 8, pc 0→1, busy high 3 cycles.
- ir = 0x4200_0010 (BRA mm=2), stat = 0010, br_go -> pc = 0x0010, br_taken one cycle. Same with stat = 0001 -> pc unchanged, br_taken 0.
- pc = 0x0005 after fetch, ir = 0x71_00FFFC (BNR mm=1), stat = 0000, br_go -> pc = 0x0001.
- pc = 0xFFFF, fetch completes -> pc = 0x0000. With IFETCH_WAIT_EN undefined, capture occurs 1 cycle after imem_rd regardless of imem_vld.
- Fetch returns 0xF0000000 -> halted = 1. Subsequent fetch_go produces no imem_rd.
- rst_f low during WAIT, imem_vld arrives after release -> ir = 0, ir_vld 0, pc = RST_VEC.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, instruction field positions and the fetch-stage state type.
package sisc_pkg;

  localparam logic [3:0] OpNoop = 4'd0;
  localparam logic [3:0] OpLod  = 4'd1;
  localparam logic [3:0] OpStr  = 4'd2;
  localparam logic [3:0] OpSwp  = 4'd3;
  localparam logic [3:0] OpBra  = 4'd4;
  localparam logic [3:0] OpBrr  = 4'd5;
  localparam logic [3:0] OpBne  = 4'd6;
  localparam logic [3:0] OpBnr  = 4'd7;
  localparam logic [3:0] OpAlu  = 4'd8;
  localparam logic [3:0] OpHlt  = 4'd15;

  localparam int unsigned OpcMsb = 31;
  localparam int unsigned OpcLsb = 28;
  localparam int unsigned MmMsb  = 27;
  localparam int unsigned MmLsb  = 24;
  localparam int unsigned OffMsb = 15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StHalt = 2'd2
  } ifetch_state_e;

endpackage

// File: rtl/sisc_br_cond.sv
// Conditional-branch resolver: decides taken and computes the target from ir, pc and status.
module sisc_br_cond
  import sisc_pkg::*;
#(
  parameter int unsigned PC_W = 16,
  parameter int unsigned IW   = 32
) (
  input  logic [IW-1:0]   i_ir,
  input  logic [PC_W-1:0] i_pc,
  input  logic [3:0]      i_stat,
  output logic            o_taken,
  output logic [PC_W-1:0] o_target
);

  logic [3:0]       w_op;
  logic [3:0]       w_mm;
  logic             w_hit;
  logic [PC_W+15:0] w_rel;
  logic             w_unused_ir;

  assign w_op  = i_ir[OpcMsb:OpcLsb];
  assign w_mm  = i_ir[MmMsb:MmLsb];
  assign w_hit = |(i_stat & w_mm);
  // Relative targets add a sign-extended 16-bit offset; the sum is truncated to PC_W.
  assign w_rel = {16'b0, i_pc} + {{PC_W{i_ir[OffMsb]}}, i_ir[OffMsb:0]};
  assign w_unused_ir = ^i_ir;

  always_comb begin
    o_taken  = 1'b0;
    o_target = i_ir[PC_W-1:0];
    case (w_op)
      OpBra: o_taken = w_hit;
      OpBrr: begin
        o_taken  = w_hit;
        o_target = w_rel[PC_W-1:0];
      end
      OpBne: o_taken = ~w_hit;
      OpBnr: begin
        o_taken  = ~w_hit;
        o_target = w_rel[PC_W-1:0];
      end
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sisc_ifetch.sv
// SISC instruction-fetch stage: PC/IR, request/valid imem read, branch resolution.
// Define IFETCH_WAIT_EN for variable-latency memory (capture gated by imem_vld).
module sisc_ifetch
  import sisc_pkg::*;
#(
  parameter int unsigned     PC_W    = 16,
  parameter int unsigned     IW      = 32,
  parameter logic [PC_W-1:0] RST_VEC = '0
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            i_fetch_go,
  input  logic            i_br_go,
  input  logic [3:0]      i_stat,
  output logic [PC_W-1:0] o_imem_addr,
  output logic            o_imem_rd,
  input  logic [IW-1:0]   i_imem_rdata,
  input  logic            i_imem_vld,
  output logic [IW-1:0]   o_ir,
  output logic [3:0]      o_opcode,
  output logic [3:0]      o_mm,
  output logic [PC_W-1:0] o_pc,
  output logic            o_ir_vld,
  output logic            o_busy,
  output logic            o_br_taken,
  output logic            o_halted
);

  ifetch_state_e   r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt, w_pc_br;
  logic [IW-1:0]   r_ir, w_ir_nxt;
  logic            r_ir_vld, w_ir_vld_nxt;
  logic            r_imem_rd, w_imem_rd_nxt;
  logic [PC_W-1:0] r_imem_addr, w_imem_addr_nxt;
  logic            r_br_taken, w_br_taken_nxt;
  logic            w_taken;
  logic [PC_W-1:0] w_target;
  logic            w_cap;

`ifdef IFETCH_WAIT_EN
  assign w_cap = i_imem_vld;
`else
  logic w_unused_vld;
  assign w_unused_vld = i_imem_vld;
  assign w_cap        = 1'b1;
`endif

  sisc_br_cond #(
    .PC_W(PC_W),
    .IW  (IW)
  ) u_br_cond (
    .i_ir    (r_ir),
    .i_pc    (r_pc),
    .i_stat  (i_stat),
    .o_taken (w_taken),
    .o_target(w_target)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state     <= StIdle;
      r_pc        <= RST_VEC;
      r_ir        <= '0;
      r_ir_vld    <= 1'b0;
      r_imem_rd   <= 1'b0;
      r_imem_addr <= '0;
      r_br_taken  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_ir        <= w_ir_nxt;
      r_ir_vld    <= w_ir_vld_nxt;
      r_imem_rd   <= w_imem_rd_nxt;
      r_imem_addr <= w_imem_addr_nxt;
      r_br_taken  <= w_br_taken_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_pc_br         = r_pc;
    w_ir_nxt        = r_ir;
    w_ir_vld_nxt    = r_ir_vld;
    w_imem_rd_nxt   = r_imem_rd;
    w_imem_addr_nxt = r_imem_addr;
    w_br_taken_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        // A same-cycle branch is applied before the fetch so the read uses the new PC.
        if (i_br_go && w_taken) begin
          w_pc_br        = w_target;
          w_br_taken_nxt = 1'b1;
        end
        w_pc_nxt = w_pc_br;
        if (i_fetch_go) begin
          w_imem_addr_nxt = w_pc_br;
          w_imem_rd_nxt   = 1'b1;
          w_state_nxt     = StWait;
        end
      end
      StWait: begin
        if (w_cap) begin
          w_ir_nxt      = i_imem_rdata;
          w_pc_nxt      = r_pc + PC_W'(1);
          w_ir_vld_nxt  = 1'b1;
          w_imem_rd_nxt = 1'b0;
          w_state_nxt   = (i_imem_rdata[OpcMsb:OpcLsb] == OpHlt) ? StHalt : StIdle;
        end
      end
      StHalt: w_state_nxt = StHalt;
      default: w_state_nxt = StIdle;
    endcase
  end

  assign o_imem_addr = r_imem_addr;
  assign o_imem_rd   = r_imem_rd;
  assign o_ir        = r_ir;
  assign o_opcode    = r_ir[OpcMsb:OpcLsb];
  assign o_mm        = r_ir[MmMsb:MmLsb];
  assign o_pc        = r_pc;
  assign o_ir_vld    = r_ir_vld;
  assign o_busy      = (r_state == StWait);
  assign o_br_taken  = r_br_taken;
  assign o_halted    = (r_state == StHalt);

endmodule

// File: tb/tb_sisc_ifetch.sv
// Self-checking bench for sisc_ifetch: branch vector table, directed corner sequences, random mix.
module tb_sisc_ifetch;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        i_fetch_go, i_br_go, i_imem_vld;
  logic [3:0]  i_stat;
  logic [31:0] i_imem_rdata;
  logic [15:0] o_imem_addr, o_pc;
  logic        o_imem_rd, o_ir_vld, o_busy, o_br_taken, o_halted;
  logic [31:0] o_ir;
  logic [3:0]  o_opcode, o_mm;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state, kept at the level of the architectural rules.
  logic [15:0] m_pc;
  logic [31:0] m_ir;
  logic        m_vld;

  typedef struct {
    logic [31:0] ir;
    logic [3:0]  st;
    logic        tk;
    logic [15:0] pc;
  } vec_t;
  vec_t vecs[12];

  sisc_ifetch #(
    .PC_W   (16),
    .IW     (32),
    .RST_VEC(16'h0000)
  ) dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .i_fetch_go  (i_fetch_go),
    .i_br_go     (i_br_go),
    .i_stat      (i_stat),
    .o_imem_addr (o_imem_addr),
    .o_imem_rd   (o_imem_rd),
    .i_imem_rdata(i_imem_rdata),
    .i_imem_vld  (i_imem_vld),
    .o_ir        (o_ir),
    .o_opcode    (o_opcode),
    .o_mm        (o_mm),
    .o_pc        (o_pc),
    .o_ir_vld    (o_ir_vld),
    .o_busy      (o_busy),
    .o_br_taken  (o_br_taken),
    .o_halted    (o_halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_br(input logic [31:0] ir, input logic [15:0] pc,
                                   input logic [3:0] st, output logic tk,
                                   output logic [15:0] tg);
    int op;
    int t;
    logic hit;
    op  = int'(ir[31:28]);
    hit = ((st & ir[27:24]) != 4'd0);
    tg  = pc;
    tk  = 1'b0;
    if (op == 4 || op == 6) tg = ir[15:0];
    if (op == 5 || op == 7) begin
      t  = int'(pc) + int'($signed(ir[15:0]));
      tg = 16'(t & 32'hFFFF);
    end
    if (op == 4 || op == 5) tk = hit;
    if (op == 6 || op == 7) tk = !hit;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_fetch_go   = 1'b0;
    i_br_go      = 1'b0;
    i_stat       = 4'd0;
    i_imem_vld   = 1'b0;
    i_imem_rdata = 32'd0;
    rst_f        = 1'b0;
    #2;
    rst_f = 1'b1;
    m_pc  = 16'h0000;
    m_ir  = 32'd0;
    m_vld = 1'b0;
  endtask

  // Full fetch; WAIT cycles are driven with fetch_go/br_go noise that must be ignored.
  task automatic fetch(input logic [31:0] data, input int lat, input logic with_br,
                       input logic [3:0] st);
    logic        tk;
    logic [15:0] tg;
    model_br(m_ir, m_pc, st, tk, tg);
    if (with_br && tk) m_pc = tg;
    i_fetch_go = 1'b1;
    i_br_go    = with_br;
    i_stat     = st;
    tick();
    i_br_go = 1'b1;
    i_stat  = 4'hF;
    chk("fetch_rd", 32'(o_imem_rd), 32'd1);
    chk("fetch_addr", 32'(o_imem_addr), 32'(m_pc));
    chk("fetch_busy", 32'(o_busy), 32'd1);
    if (with_br) chk("fetch_br_taken", 32'(o_br_taken), 32'(tk));
`ifdef IFETCH_WAIT_EN
    for (int c = 1; c < lat; c++) begin
      i_imem_vld   = 1'b0;
      i_imem_rdata = ~data;
      tick();
      chk("wait_busy", 32'(o_busy), 32'd1);
      chk("wait_rd", 32'(o_imem_rd), 32'd1);
      chk("wait_addr", 32'(o_imem_addr), 32'(m_pc));
      chk("wait_pc", 32'(o_pc), 32'(m_pc));
    end
    i_imem_vld   = 1'b1;
    i_imem_rdata = data;
`else
    i_imem_vld   = 1'b0;
    i_imem_rdata = data;
`endif
    tick();
    i_imem_vld = 1'b0;
    i_fetch_go = 1'b0;
    i_br_go    = 1'b0;
    m_ir  = data;
    m_pc  = m_pc + 16'd1;
    m_vld = 1'b1;
    chk("cap_ir", o_ir, m_ir);
    chk("cap_opcode", 32'(o_opcode), 32'(data[31:28]));
    chk("cap_mm", 32'(o_mm), 32'(data[27:24]));
    chk("cap_pc", 32'(o_pc), 32'(m_pc));
    chk("cap_ir_vld", 32'(o_ir_vld), 32'd1);
    chk("cap_rd", 32'(o_imem_rd), 32'd0);
    chk("cap_busy", 32'(o_busy), 32'd0);
    chk("cap_halted", 32'(o_halted), 32'(data[31:28] == 4'hF));
    chk("cap_br_taken", 32'(o_br_taken), 32'd0);
  endtask

  task automatic branch(input logic [3:0] st);
    logic        tk;
    logic [15:0] tg;
    model_br(m_ir, m_pc, st, tk, tg);
    i_br_go = 1'b1;
    i_stat  = st;
    tick();
    i_br_go = 1'b0;
    if (tk) m_pc = tg;
    chk("br_taken", 32'(o_br_taken), 32'(tk));
    chk("br_pc", 32'(o_pc), 32'(m_pc));
    tick();
    chk("br_taken_clear", 32'(o_br_taken), 32'd0);
    chk("br_pc_hold", 32'(o_pc), 32'(m_pc));
  endtask

  initial begin
    int lat;
    logic [31:0] data;
    vecs[0]  = '{32'h4200_0010, 4'h2, 1'b1, 16'h0010};
    vecs[1]  = '{32'h4200_0010, 4'h1, 1'b0, 16'h0001};
    vecs[2]  = '{32'h5300_FFFF, 4'h2, 1'b1, 16'h0000};
    vecs[3]  = '{32'h6400_1234, 4'h4, 1'b0, 16'h0001};
    vecs[4]  = '{32'h6400_1234, 4'h3, 1'b1, 16'h1234};
    vecs[5]  = '{32'h7100_FFFC, 4'h0, 1'b1, 16'hFFFD};
    vecs[6]  = '{32'h7F00_8000, 4'h8, 1'b0, 16'h0001};
    vecs[7]  = '{32'h8812_0000, 4'hF, 1'b0, 16'h0001};
    vecs[8]  = '{32'h4000_0000, 4'hF, 1'b0, 16'h0001};
    vecs[9]  = '{32'h6000_ABCD, 4'h0, 1'b1, 16'hABCD};
    vecs[10] = '{32'h0000_0005, 4'hF, 1'b0, 16'h0001};
    vecs[11] = '{32'h5F00_7FFF, 4'h1, 1'b1, 16'h8000};

    do_reset();
    chk("rst_pc", 32'(o_pc), 32'h0);
    chk("rst_ir", o_ir, 32'h0);
    chk("rst_ir_vld", 32'(o_ir_vld), 32'd0);
    chk("rst_rd", 32'(o_imem_rd), 32'd0);
    chk("rst_addr", 32'(o_imem_addr), 32'h0);
    chk("rst_br_taken", 32'(o_br_taken), 32'd0);
    chk("rst_halted", 32'(o_halted), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);

    // First fetch, three-cycle memory latency where supported.
    fetch(32'h8812_0000, 3, 1'b0, 4'd0);
    chk("first_pc", 32'(o_pc), 32'h1);
    chk("first_opcode", 32'(o_opcode), 32'h8);

    // Branch table: each vector starts from reset with the instruction fetched at pc 0.
    foreach (vecs[i]) begin
      do_reset();
      fetch(vecs[i].ir, 1, 1'b0, 4'd0);
      i_br_go = 1'b1;
      i_stat  = vecs[i].st;
      tick();
      i_br_go = 1'b0;
      chk($sformatf("vec%0d_taken", i), 32'(o_br_taken), 32'(vecs[i].tk));
      chk($sformatf("vec%0d_pc", i), 32'(o_pc), 32'(vecs[i].pc));
      tick();
      chk($sformatf("vec%0d_taken_clr", i), 32'(o_br_taken), 32'd0);
      m_pc = vecs[i].pc;
    end

    // BNR back from pc 5 to pc 1.
    do_reset();
    fetch(32'h4400_0004, 1, 1'b0, 4'd0);
    branch(4'h4);
    fetch(32'h7100_FFFC, 2, 1'b0, 4'd0);
    chk("bnr_pre_pc", 32'(o_pc), 32'h5);
    branch(4'h0);
    chk("bnr_pc", 32'(o_pc), 32'h1);

    // PC wrap, then fetch and branch in the same cycle.
    fetch(32'h4100_FFFF, 1, 1'b0, 4'd0);
    branch(4'h1);
    chk("wrap_pre_pc", 32'(o_pc), 32'hFFFF);
    fetch(32'h4200_0030, 2, 1'b0, 4'd0);
    chk("wrap_pc", 32'(o_pc), 32'h0);
    fetch(32'h8812_0000, 1, 1'b1, 4'h2);
    chk("fetch_br_pc", 32'(o_pc), 32'h31);

    // imem_vld while idle is ignored.
    i_imem_vld   = 1'b1;
    i_imem_rdata = 32'hDEAD_BEEF;
    tick();
    i_imem_vld = 1'b0;
    chk("idle_vld_ir", o_ir, 32'h8812_0000);
    chk("idle_vld_pc", 32'(o_pc), 32'h31);
    chk("idle_vld_busy", 32'(o_busy), 32'd0);

    // Reset in the middle of a read.
    i_fetch_go = 1'b1;
    tick();
    i_fetch_go = 1'b0;
    chk("mid_busy", 32'(o_busy), 32'd1);
    rst_f = 1'b0;
    #1;
    chk("mid_rst_rd", 32'(o_imem_rd), 32'd0);
    chk("mid_rst_addr", 32'(o_imem_addr), 32'h0);
    chk("mid_rst_pc", 32'(o_pc), 32'h0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    #1;
    rst_f        = 1'b1;
    i_imem_vld   = 1'b1;
    i_imem_rdata = 32'h1234_5678;
    tick();
    i_imem_vld = 1'b0;
    chk("post_rst_ir", o_ir, 32'h0);
    chk("post_rst_ir_vld", 32'(o_ir_vld), 32'd0);
    chk("post_rst_pc", 32'(o_pc), 32'h0);
    m_pc  = 16'h0;
    m_ir  = 32'h0;
    m_vld = 1'b0;

    // Randomized mix of fetches and branches against the reference model.
    for (int it = 0; it < 80; it++) begin
      data = $urandom;
      if ($urandom_range(0, 3) == 0) data[31:28] = 4'($urandom_range(0, 14));
      else data[31:28] = 4'(4 + $urandom_range(0, 3));
      lat = int'($urandom_range(1, 4));
      case ($urandom_range(0, 2))
        0: fetch(data, lat, 1'b0, 4'd0);
        1: branch(4'($urandom));
        default: fetch(data, lat, 1'b1, 4'($urandom));
      endcase
    end

    // HLT latches; later fetch_go/br_go are ignored.
    fetch(32'hF000_0000, 2, 1'b0, 4'd0);
    i_fetch_go = 1'b1;
    i_br_go    = 1'b1;
    i_stat     = 4'hF;
    tick();
    tick();
    i_fetch_go = 1'b0;
    i_br_go    = 1'b0;
    chk("halt_rd", 32'(o_imem_rd), 32'd0);
    chk("halt_busy", 32'(o_busy), 32'd0);
    chk("halt_halted", 32'(o_halted), 32'd1);
    chk("halt_pc", 32'(o_pc), 32'(m_pc));
    chk("halt_br_taken", 32'(o_br_taken), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
